// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU sitting directly upstream of the accumulator.
//            Single-cycle ops (PASS_B/ADD/SUB/AND/OR) finish on the start
//            edge. MUL (shift-add) and DIV (restoring) iterate for N cycles.
//            done is a one-cycle strobe that loads the accumulator.
//            Optional macro SEQ_ALU_MOD_EN enables op 111 = MOD (remainder);
//            without it op 111 is illegal and yields 0 in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] alu_out,
    output logic         z,
    output logic         dz
);

    localparam int         c_cw      = $clog2(N);

    localparam logic [2:0] c_op_pass = 3'b000;
    localparam logic [2:0] c_op_add  = 3'b001;
    localparam logic [2:0] c_op_sub  = 3'b010;
    localparam logic [2:0] c_op_and  = 3'b011;
    localparam logic [2:0] c_op_or   = 3'b100;
    localparam logic [2:0] c_op_mul  = 3'b101;
    localparam logic [2:0] c_op_div  = 3'b110;
    localparam logic [2:0] c_op_mod  = 3'b111;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_cw-1:0] r_count;
    // MUL: r_opa = shifting multiplicand, r_opb = shifting multiplier,
    //      r_acc = partial product.
    // DIV: r_opa = divisor, r_opb = dividend shifting into quotient,
    //      r_acc = partial remainder.
    logic [N-1:0]    r_opa;
    logic [N-1:0]    r_opb;
    logic [N-1:0]    r_acc;
    logic            r_done;
    logic [N-1:0]    r_alu_out;
    logic            r_z;
    logic            r_dz;

    logic            w_b_zero;
    logic            w_divlike;
    logic            w_go_mul;
    logic            w_go_div;
    logic            w_last;
    logic [N-1:0]    w_single_res;
    logic            w_single_dz;
    logic [N-1:0]    w_mul_acc;
    logic [N:0]      w_div_shift;
    logic [N:0]      w_div_diff;
    logic            w_div_ok;
    logic [N-1:0]    w_rem_next;
    logic [N-1:0]    w_quo_next;
    logic [N-1:0]    w_div_fin;

`ifdef SEQ_ALU_MOD_EN
    logic            r_is_mod;
    assign w_divlike = (op == c_op_div) || (op == c_op_mod);
    assign w_div_fin = r_is_mod ? w_rem_next : w_quo_next;
`else
    assign w_divlike = (op == c_op_div);
    assign w_div_fin = w_quo_next;
`endif

    assign w_b_zero = (b == '0);
    assign w_go_mul = start && (op == c_op_mul);
    assign w_go_div = start && w_divlike && !w_b_zero;
    assign w_last   = (r_count == '0);

    // One shift-add step: add the multiplicand when the multiplier LSB is set
    assign w_mul_acc   = r_acc + (r_opb[0] ? r_opa : '0);

    // One restoring-division step: shift in the next dividend bit, trial subtract
    assign w_div_shift = {r_acc, r_opb[N-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opa};
    assign w_div_ok    = ~w_div_diff[N];
    assign w_rem_next  = w_div_ok ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
    assign w_quo_next  = {r_opb[N-2:0], w_div_ok};

    // Single-cycle result; DIV/MOD only land here when b is zero
    always_comb begin
        w_single_res = '0;
        w_single_dz  = 1'b0;
        case (op)
            c_op_pass: w_single_res = b;
            c_op_add:  w_single_res = a + b;
            c_op_sub:  w_single_res = a - b;
            c_op_and:  w_single_res = a & b;
            c_op_or:   w_single_res = a | b;
            c_op_div: begin
                w_single_res = '1;
                w_single_dz  = 1'b1;
            end
`ifdef SEQ_ALU_MOD_EN
            c_op_mod: begin
                w_single_res = a;
                w_single_dz  = 1'b1;
            end
`endif
            default:   w_single_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: multi-cycle ops return to IDLE on their last iteration
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_go_mul) begin
                    w_state_next = c_st_mul;
                end else if (w_go_div) begin
                    w_state_next = c_st_div;
                end
            end
            c_st_mul: if (w_last) w_state_next = c_st_idle;
            c_st_div: if (w_last) w_state_next = c_st_idle;
            default:  w_state_next = c_st_idle;
        endcase
    end

    // Datapath: operand capture, iteration and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_alu_out <= '0;
            r_z       <= 1'b0;
            r_dz      <= 1'b0;
`ifdef SEQ_ALU_MOD_EN
            r_is_mod  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_go_mul || w_go_div) begin
                        r_opa   <= w_go_mul ? a : b;
                        r_opb   <= w_go_mul ? b : a;
                        r_acc   <= '0;
                        r_count <= c_cw'(N - 1);
`ifdef SEQ_ALU_MOD_EN
                        r_is_mod <= (op == c_op_mod);
`endif
                    end else if (start) begin
                        r_alu_out <= w_single_res;
                        r_z       <= (w_single_res == '0);
                        r_dz      <= w_single_dz;
                        r_done    <= 1'b1;
                    end
                end
                c_st_mul: begin
                    r_acc <= w_mul_acc;
                    r_opa <= r_opa << 1;
                    r_opb <= r_opb >> 1;
                    if (w_last) begin
                        r_alu_out <= w_mul_acc;
                        r_z       <= (w_mul_acc == '0);
                        r_dz      <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                c_st_div: begin
                    r_acc <= w_rem_next;
                    r_opb <= w_quo_next;
                    if (w_last) begin
                        r_alu_out <= w_div_fin;
                        r_z       <= (w_div_fin == '0);
                        r_dz      <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != c_st_idle);
    assign done    = r_done;
    assign alu_out = r_alu_out;
    assign z       = r_z;
    assign dz      = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Self-checking bench for seq_alu (N=16): vector table plus
//            hand-written sequences for busy-ignore, back-to-back and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] alu_out;
    logic         z;
    logic         dz;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        ez;
        logic        edz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .alu_out (alu_out),
        .z       (z),
        .dz      (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done, bounded; returns cycles elapsed since the start edge
    task automatic wait_done(output int n, output bit busy_drop);
        n = 0;
        busy_drop = 0;
        while (!done && n < 40) begin
            if (!busy) busy_drop = 1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit bd;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(7));
        a     = 16'($urandom);
        b     = 16'($urandom);
        check($sformatf("v%0d busy_after_start", idx), {31'd0, busy}, {31'd0, (v.lat != 0)});
        wait_done(n, bd);
        check($sformatf("v%0d done_seen", idx), {31'd0, done}, 32'd1);
        check($sformatf("v%0d latency", idx), n, v.lat);
        check($sformatf("v%0d alu_out", idx), {16'd0, alu_out}, {16'd0, v.exp});
        check($sformatf("v%0d z", idx), {31'd0, z}, {31'd0, v.ez});
        check($sformatf("v%0d dz", idx), {31'd0, dz}, {31'd0, v.edz});
        check($sformatf("v%0d busy_at_done", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d busy_held", idx), {31'd0, bd}, 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d done_one_cycle", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d alu_out_hold", idx), {16'd0, alu_out}, {16'd0, v.exp});
    endtask

    initial begin
        int  n;
        bit  bd;
        int  late_done;

        //           op      a        b        exp      z     dz    lat
        vecs.push_back('{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0});
        vecs.push_back('{3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 0});
        vecs.push_back('{3'b101, 16'd300,  16'd5,    16'h05DC, 1'b0, 1'b0, 16});
        vecs.push_back('{3'b101, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 16});
        vecs.push_back('{3'b101, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16});
        vecs.push_back('{3'b110, 16'd100,  16'd7,    16'd14,   1'b0, 1'b0, 16});
        vecs.push_back('{3'b110, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0});
        vecs.push_back('{3'b001, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0});
        vecs.push_back('{3'b000, 16'h1111, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 0});
        vecs.push_back('{3'b011, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 0});
        vecs.push_back('{3'b100, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 0});
        vecs.push_back('{3'b110, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16});
        vecs.push_back('{3'b110, 16'd5,    16'd9,    16'h0000, 1'b1, 1'b0, 16});
        vecs.push_back('{3'b110, 16'd50000,16'd123,  16'd406,  1'b0, 1'b0, 16});
`ifdef SEQ_ALU_MOD_EN
        vecs.push_back('{3'b111, 16'd100,  16'd7,    16'd2,    1'b0, 1'b0, 16});
        vecs.push_back('{3'b111, 16'd50000,16'd123,  16'd62,   1'b0, 1'b0, 16});
        vecs.push_back('{3'b111, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1, 0});
`else
        vecs.push_back('{3'b111, 16'd100,  16'd7,    16'h0000, 1'b1, 1'b0, 0});
`endif

        rst_n = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset alu_out", {16'd0, alu_out}, 32'd0);
        check("reset z", {31'd0, z}, 32'd0);
        check("reset dz", {31'd0, dz}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // start pulses while MUL is busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 16'd300; b = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'b001; a = 16'd1; b = 16'd1;
        @(negedge clk);
        start = 1'b0; a = 16'h7777; b = 16'h0003;
        @(negedge clk);
        start = 1'b1; op = 3'b001;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        wait_done(n, bd);
        check("ignore done_seen", {31'd0, done}, 32'd1);
        check("ignore latency", n + 5, 16);
        check("ignore alu_out", {16'd0, alu_out}, 32'h05DC);
        check("ignore busy_held", {31'd0, bd}, 32'd0);

        // back-to-back: new start during the done cycle is accepted
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 16'd1; b = 16'd1;
        @(posedge clk);
        #1;
        check("b2b first done", {31'd0, done}, 32'd1);
        check("b2b first alu_out", {16'd0, alu_out}, 32'd2);
        op = 3'b001; a = 16'd2; b = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second done", {31'd0, done}, 32'd1);
        check("b2b second alu_out", {16'd0, alu_out}, 32'd5);
        @(posedge clk);
        #1;
        check("b2b done drops", {31'd0, done}, 32'd0);

        // reset mid-MUL aborts immediately with no later done
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 16'd300; b = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("prereset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort alu_out", {16'd0, alu_out}, 32'd0);
        check("abort z", {31'd0, z}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_done++;
        end
        check("abort no late done", late_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
